// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one UART transmitter to one of four byte sources.
// A grant is held across a message, up to MAX_BURST bytes, or until the holder goes quiet.
//
// state     | meaning
// IDLE      | no grant; arbitrate when a request is present and the transmitter is free
// SEND      | one cycle: pulse tx_start and req_ready to the holder
// WAIT_BUSY | wait for the transmitter to report the frame in progress
// WAIT_DONE | wait for the frame to finish; release or keep the grant
// HOLD      | keep the grant, waiting for the holder's next byte or the timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [1:0]             grant_id,
  output logic                   grant_active
);

  localparam logic [4:0] BURST_MAX = 5'(MAX_BURST);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_id_q, grant_id_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic        grant_active_q, grant_active_d;
  logic [4:0]  burst_q, burst_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        msg_last_q, msg_last_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic [1:0]  winner;
  logic [1:0]  rr_idx;
  logic        found;
  logic        rel;

  // Search starts just past the previous holder so every source gets a turn.
  always_comb begin
    winner = last_grant_q;
    rr_idx = last_grant_q;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = last_grant_q + 2'(i);
      if (!found && req_valid[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    grant_active_d = grant_active_q;
    burst_d        = burst_q;
    hold_cnt_d     = hold_cnt_q;
    msg_last_d     = msg_last_q;
    tx_data_d      = tx_data_q;
    rel            = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req_valid && !tx_busy) begin
          state_d        = SEND;
          grant_id_d     = winner;
          grant_active_d = 1'b1;
          tx_data_d      = req_data[{winner, 3'b000} +: 8];
        end
      end
      SEND: begin
        burst_d    = (burst_q == BURST_MAX) ? burst_q : burst_q + 5'd1;
        msg_last_d = req_last[grant_id_q];
        hold_cnt_d = 8'd0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (msg_last_q || burst_q == BURST_MAX) rel = 1'b1;
          else                                    state_d = HOLD;
        end
      end
      HOLD: begin
        if (req_valid[grant_id_q]) begin
          state_d   = SEND;
          tx_data_d = req_data[{grant_id_q, 3'b000} +: 8];
        end else if (hold_cnt_q == HOLD_LAST) begin
          rel = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      state_d        = IDLE;
      last_grant_d   = grant_id_q;
      burst_d        = 5'd0;
      hold_cnt_d     = 8'd0;
      grant_active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_id_q     <= 2'd0;
      last_grant_q   <= 2'd3;
      grant_active_q <= 1'b0;
      burst_q        <= 5'd0;
      hold_cnt_q     <= 8'd0;
      msg_last_q     <= 1'b0;
      tx_data_q      <= 8'h00;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      grant_active_q <= grant_active_d;
      burst_q        <= burst_d;
      hold_cnt_q     <= hold_cnt_d;
      msg_last_q     <= msg_last_d;
      tx_data_q      <= tx_data_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == SEND) req_ready[grant_id_q] = 1'b1;
  end

  assign tx_start     = (state_q == SEND);
  assign tx_data      = tx_data_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;

endmodule
